// File: rtl/bound_flasher_monitor_pkg.sv
// Shared encodings and helpers for the bound flasher LED bus monitor.
package bound_flasher_monitor_pkg;

  localparam int LED_W = 16;
  localparam logic [4:0] LEVEL_FULL = 5'd16;
  localparam logic [4:0] LEVEL_EMPTY = 5'd0;

  // Direction reported on the dir output; doubles as the monitor FSM state.
  typedef enum logic [1:0] {
    DIR_IDLE  = 2'd0,
    DIR_RISE  = 2'd1,
    DIR_FALL  = 2'd2,
    DIR_BLINK = 2'd3
  } dir_e;

  // First-error code latched on err_code.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_STEP   = 2'd1,
    ERR_PEAK   = 2'd2,
    ERR_TROUGH = 2'd3
  } err_e;

  // Level to adopt after an illegal step: only the all-off and all-on
  // patterns give an unambiguous level, otherwise keep what we had.
  function automatic logic [4:0] resync_level(input logic [LED_W-1:0] led,
                                              input logic [4:0] level);
    logic [4:0] result;
    if (led == {LED_W{1'b0}}) begin
      result = LEVEL_EMPTY;
    end else if (led == {LED_W{1'b1}}) begin
      result = LEVEL_FULL;
    end else begin
      result = level;
    end
    return result;
  endfunction

endpackage

// File: rtl/bound_flasher_monitor_led_step_classifier.sv
// Combinational classification of one LED bus transition against the
// previous sample: fill-shift-left, shift-right, hold or blink toggle.
module led_step_classifier
  import bound_flasher_monitor_pkg::*;
(
  input  logic [LED_W-1:0] led,
  input  logic [LED_W-1:0] led_q,
  output logic             up,
  output logic             down,
  output logic             hold,
  output logic             toggle
);

  logic prev_zero_s;
  logic prev_full_s;

  assign prev_zero_s = (led_q == {LED_W{1'b0}});
  assign prev_full_s = (led_q == {LED_W{1'b1}});

  // A fill step shifts a one in from the bottom; impossible once all lit.
  assign up     = (led == {led_q[LED_W-2:0], 1'b1}) && !prev_full_s;
  // A drain step shifts right; impossible once all dark.
  assign down   = (led == (led_q >> 1)) && !prev_zero_s;
  assign hold   = (led == led_q);
  // Blink only flips between fully dark and fully lit.
  assign toggle = (led == ~led_q) && (prev_zero_s || prev_full_s);

endmodule

// File: rtl/bound_flasher_monitor.sv
// Passive monitor for the bound flasher LED bus: tracks fill level and
// direction, checks every transition, latches the first error and counts
// completed runs (rise/fall sequence ending in a full-on/full-off blink).
module bound_flasher_monitor
  import bound_flasher_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PEAK_A   = 6,
  parameter int PEAK_B   = 11,
  parameter int TROUGH_B = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] led,
  input  logic             clr_err,
  output logic [4:0]       level,
  output logic [1:0]       dir,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             run_done,
  output logic [CNT_W-1:0] run_count
);

  logic [LED_W-1:0] led_q_r;
  logic [4:0]       level_r;
  dir_e             state_r;
  logic             err_r;
  err_e             err_code_r;
  logic             run_done_r;
  logic [CNT_W-1:0] run_count_r;
  logic [1:0]       blink_n_r;
  logic             saw16_r;

  logic up_s;
  logic down_s;
  logic hold_s;
  logic toggle_s;
  logic peak_ok_s;
  logic trough_ok_s;
  logic led_zero_s;
  logic led_full_s;
  err_e new_err_s;

  led_step_classifier u_classifier (
    .led    (led),
    .led_q  (led_q_r),
    .up     (up_s),
    .down   (down_s),
    .hold   (hold_s),
    .toggle (toggle_s)
  );

  assign led_zero_s  = (led == {LED_W{1'b0}});
  assign led_full_s  = (led == {LED_W{1'b1}});
  assign peak_ok_s   = (level_r == 5'(PEAK_A)) || (level_r == 5'(PEAK_B)) ||
                       (level_r == LEVEL_FULL);
  assign trough_ok_s = (level_r == LEVEL_EMPTY) || (level_r == 5'(TROUGH_B));

  // Decide which error, if any, the current transition represents.
  always_comb begin
    new_err_s = ERR_NONE;
    case (state_r)
      DIR_IDLE: begin
        if (hold_s || up_s) begin
          new_err_s = ERR_NONE;
        end else begin
          new_err_s = ERR_STEP;
        end
      end
      DIR_RISE: begin
        if (hold_s || up_s) begin
          new_err_s = ERR_NONE;
        end else if (down_s) begin
          new_err_s = peak_ok_s ? ERR_NONE : ERR_PEAK;
        end else begin
          new_err_s = ERR_STEP;
        end
      end
      DIR_FALL: begin
        if (hold_s || down_s) begin
          new_err_s = ERR_NONE;
        end else if (up_s) begin
          new_err_s = trough_ok_s ? ERR_NONE : ERR_TROUGH;
        end else begin
          new_err_s = ERR_STEP;
        end
      end
      DIR_BLINK: begin
        if (hold_s || toggle_s) begin
          new_err_s = ERR_NONE;
        end else begin
          new_err_s = ERR_STEP;
        end
      end
      default: new_err_s = ERR_STEP;
    endcase
  end

  // Monitor FSM: sample history, level/direction tracking, sticky error, run counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q_r     <= {LED_W{1'b0}};
      level_r     <= LEVEL_EMPTY;
      state_r     <= DIR_IDLE;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
      run_done_r  <= 1'b0;
      run_count_r <= {CNT_W{1'b0}};
      blink_n_r   <= 2'd0;
      saw16_r     <= 1'b0;
    end else begin
      led_q_r    <= led;
      run_done_r <= 1'b0;

      // First error sticks; a clear coinciding with a new error keeps the new one.
      if ((new_err_s != ERR_NONE) && (!err_r || clr_err)) begin
        err_r      <= 1'b1;
        err_code_r <= new_err_s;
      end else if (clr_err) begin
        err_r      <= 1'b0;
        err_code_r <= ERR_NONE;
      end else begin
        err_r      <= err_r;
        err_code_r <= err_code_r;
      end

      case (state_r)
        DIR_IDLE: begin
          if (hold_s) begin
            level_r <= level_r;
          end else if (up_s) begin
            state_r <= DIR_RISE;
            level_r <= 5'd1;
          end else begin
            level_r <= LEVEL_EMPTY;
          end
        end
        DIR_RISE: begin
          if (hold_s) begin
            level_r <= level_r;
          end else if (up_s) begin
            level_r <= level_r + 5'd1;
          end else if (down_s) begin
            level_r <= level_r - 5'd1;
            saw16_r <= saw16_r | (level_r == LEVEL_FULL);
            if ((level_r == 5'd1) && saw16_r) begin
              state_r   <= DIR_BLINK;
              blink_n_r <= 2'd0;
            end else begin
              state_r <= DIR_FALL;
            end
          end else begin
            level_r <= resync_level(led, level_r);
            state_r <= led_zero_s ? DIR_IDLE : state_r;
          end
        end
        DIR_FALL: begin
          if (hold_s) begin
            level_r <= level_r;
          end else if (down_s) begin
            level_r <= level_r - 5'd1;
            if ((level_r == 5'd1) && saw16_r) begin
              state_r   <= DIR_BLINK;
              blink_n_r <= 2'd0;
            end else begin
              state_r <= DIR_FALL;
            end
          end else if (up_s) begin
            level_r <= level_r + 5'd1;
            state_r <= DIR_RISE;
          end else begin
            level_r <= resync_level(led, level_r);
            state_r <= led_zero_s ? DIR_IDLE : state_r;
          end
        end
        DIR_BLINK: begin
          if (hold_s) begin
            level_r <= level_r;
          end else if (toggle_s) begin
            level_r <= led_full_s ? LEVEL_FULL : LEVEL_EMPTY;
            if ((blink_n_r == 2'd1) && led_zero_s) begin
              run_done_r <= 1'b1;
              if (run_count_r != {CNT_W{1'b1}}) begin
                run_count_r <= run_count_r + CNT_W'(1);
              end else begin
                run_count_r <= run_count_r;
              end
              saw16_r   <= 1'b0;
              blink_n_r <= 2'd0;
              state_r   <= DIR_IDLE;
            end else begin
              blink_n_r <= blink_n_r + 2'd1;
            end
          end else begin
            level_r <= resync_level(led, level_r);
            state_r <= led_zero_s ? DIR_IDLE : state_r;
          end
        end
        default: begin
          state_r <= DIR_IDLE;
          level_r <= LEVEL_EMPTY;
        end
      endcase
    end
  end

  assign level     = level_r;
  assign dir       = state_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign run_done  = run_done_r;
  assign run_count = run_count_r;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Bench for the bound flasher monitor: directed LED sequences, an
// integer-level reference model checked every cycle, and literal checkpoints.
module tb_bound_flasher_monitor;

  localparam int MAXCNT = 255;
  localparam int PH_IDLE = 0, PH_RISE = 1, PH_FALL = 2, PH_BLINK = 3;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic        clr_err;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic        err;
  logic [1:0]  err_code;
  logic        run_done;
  logic [7:0]  run_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int cur = 0;

  // Reference model state (plain integers).
  int m_prev, m_level, m_phase, m_code, m_count, m_blinks;
  bit m_err, m_done, m_saw16;

  bound_flasher_monitor #(.CNT_W(8), .PEAK_A(6), .PEAK_B(11), .TROUGH_B(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .led       (led),
    .clr_err   (clr_err),
    .level     (level),
    .dir       (dir),
    .err       (err),
    .err_code  (err_code),
    .run_done  (run_done),
    .run_count (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fill(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  // Reference: what the monitor must report after sampling v.
  task automatic model_step(input int v, input bit r, input bit c);
    int  prev;
    int  ecode;
    bit  up, dn, hd, tg;
    if (r) begin
      m_prev = 0; m_level = 0; m_phase = PH_IDLE; m_err = 0; m_code = 0;
      m_done = 0; m_count = 0; m_blinks = 0; m_saw16 = 0;
      return;
    end
    prev   = m_prev;
    m_prev = v;
    m_done = 0;
    ecode  = 0;
    up = (v == ((prev * 2 + 1) % 65536)) && (prev != 65535);
    dn = (prev != 0) && (v == prev / 2);
    hd = (v == prev);
    tg = (prev == 0 || prev == 65535) && (v == 65535 - prev);
    if (!hd) begin
      case (m_phase)
        PH_IDLE: begin
          if (up) begin m_phase = PH_RISE; m_level = 1; end
          else begin ecode = 1; m_level = 0; end
        end
        PH_RISE: begin
          if (up) m_level++;
          else if (dn) begin
            if (!(m_level == 6 || m_level == 11 || m_level == 16)) ecode = 2;
            if (m_level == 16) m_saw16 = 1;
            m_level--;
            m_phase = PH_FALL;
          end else ecode = 1;
        end
        PH_FALL: begin
          if (dn) m_level--;
          else if (up) begin
            if (!(m_level == 0 || m_level == 5)) ecode = 3;
            m_level++;
            m_phase = PH_RISE;
          end else ecode = 1;
        end
        default: begin
          if (tg) begin
            m_blinks++;
            m_level = (v == 65535) ? 16 : 0;
            if (m_blinks == 2 && v == 0) begin
              m_done = 1;
              if (m_count < MAXCNT) m_count++;
              m_saw16 = 0; m_blinks = 0; m_phase = PH_IDLE;
            end
          end else ecode = 1;
        end
      endcase
      if (ecode == 1 && m_phase != PH_IDLE) begin
        if (v == 0) begin m_level = 0; m_phase = PH_IDLE; end
        else if (v == 65535) m_level = 16;
      end
      if (m_phase == PH_FALL && m_level == 0 && m_saw16) begin
        m_phase = PH_BLINK; m_blinks = 0;
      end
    end
    if (ecode != 0 && (!m_err || c)) begin m_err = 1; m_code = ecode; end
    else if (c) begin m_err = 0; m_code = 0; end
  endtask

  // Drive one sample, let the DUT clock it, advance the model; ends on a negedge.
  task automatic step(input logic [15:0] v, input logic c, input logic r);
    led = v; clr_err = c; rst = r;
    @(posedge clk);
    model_step(int'(v), r, c);
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    step(16'h0000, 1'b0, 1'b1);
    cur = 0;
  endtask

  task automatic ramp(input int target);
    while (cur < target) begin cur++; step(fill(cur), 1'b0, 1'b0); end
    while (cur > target) begin cur--; step(fill(cur), 1'b0, 1'b0); end
  endtask

  task automatic full_run();
    ramp(16);
    ramp(0);
    step(16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("level",     int'(level),     m_level);
      cmp("dir",       int'(dir),       m_phase);
      cmp("err",       int'(err),       int'(m_err));
      cmp("err_code",  int'(err_code),  m_code);
      cmp("run_done",  int'(run_done),  int'(m_done));
      cmp("run_count", int'(run_count), m_count);
    end
  end

  initial begin
    rst = 1'b1; led = 16'h0000; clr_err = 1'b0;
    @(negedge clk);
    reset_dut();
    reset_dut();
    cmp("rst_level", int'(level), 0);
    cmp("rst_dir", int'(dir), 0);
    cmp("rst_count", int'(run_count), 0);

    // Nominal run with peaks 6, 11, 16 and troughs 0, 5.
    ramp(6); ramp(0); ramp(11); ramp(5); ramp(16); ramp(0);
    cmp("nom_blink_dir", int'(dir), 3);
    step(16'hFFFF, 1'b0, 1'b0);
    cmp("nom_blink_level", int'(level), 16);
    step(16'h0000, 1'b0, 1'b0);
    cmp("nom_done", int'(run_done), 1);
    cmp("nom_count", int'(run_count), 1);
    step(16'h0000, 1'b0, 1'b0);
    cmp("nom_done_pulse", int'(run_done), 0);
    cmp("nom_dir_idle", int'(dir), 0);
    cmp("nom_err", int'(err), 0);

    // Kickback between 11 and 5 twice.
    reset_dut();
    ramp(11); ramp(5); ramp(11); ramp(5); ramp(16); ramp(0);
    step(16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    cmp("kick_count", int'(run_count), 1);
    cmp("kick_err", int'(err), 0);

    // Illegal peak at 8, then a clear colliding with a new step error.
    reset_dut();
    ramp(8); ramp(7);
    cmp("peak_err", int'(err), 1);
    cmp("peak_code", int'(err_code), 2);
    cmp("peak_level", int'(level), 7);
    step(16'h0000, 1'b1, 1'b0);
    cmp("clr_vs_new_code", int'(err_code), 1);
    step(16'h0000, 1'b1, 1'b0);
    cmp("clr_err", int'(err), 0);

    // Illegal step, first error kept, then cleared.
    reset_dut();
    ramp(6);
    step(16'h00FF, 1'b0, 1'b0);
    cmp("step_code", int'(err_code), 1);
    cmp("step_level", int'(level), 6);
    step(16'h00F0, 1'b0, 1'b0);
    cmp("step_sticky", int'(err_code), 1);
    step(16'h00F0, 1'b1, 1'b0);
    cmp("step_clr", int'(err), 0);

    // Bad trough at 3.
    reset_dut();
    ramp(11); ramp(3); ramp(4);
    cmp("trough_code", int'(err_code), 3);
    cmp("trough_dir", int'(dir), 1);

    // Reset in the middle of a run.
    reset_dut();
    full_run();
    cmp("mid_count1", int'(run_count), 1);
    ramp(9);
    reset_dut();
    cmp("mid_level", int'(level), 0);
    cmp("mid_dir", int'(dir), 0);
    cmp("mid_count0", int'(run_count), 0);
    full_run();
    cmp("mid_recount", int'(run_count), 1);

    // First sample after reset is compared against an all-dark history.
    step(16'h0003, 1'b0, 1'b1);
    step(16'h0003, 1'b0, 1'b0);
    cmp("post_rst_code", int'(err_code), 1);

    // Run counter saturation.
    reset_dut();
    for (int i = 0; i < 256; i++) full_run();
    cmp("sat_count", int'(run_count), 255);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bound_flasher_monitor.md
Name: bound_flasher_monitor

Overview:
- Passive observer on the 16-bit LED bus driven by the bound flasher; the receiving end of that interface.
- Samples the bus every clock and checks that each change is a legal flasher step: fill-shift-left, shift-right, hold, or the end-of-run blink toggle.
- Tracks fill level, direction, peaks and troughs; flags illegal behaviour with a sticky error code; counts completed flasher runs.
- Sits beside the flasher in the top level or bench; it drives nothing back into the flasher.

Parameters:
- CNT_W, 8, width of completed-run counter (saturating)
- PEAK_A, 6, first legal turn-down level
- PEAK_B, 11, second legal turn-down level
- TROUGH_B, 5, nonzero legal turn-up level

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- led  in  16  observed LED bus
- clr_err  in  1  single-cycle pulse; clears err and err_code
- level  out  5  lit-LED count, 0..16
- dir  out  2  0 idle, 1 rising, 2 falling, 3 blink
- err  out  1  sticky error flag
- err_code  out  2  first error: 1 step, 2 peak, 3 trough
- run_done  out  1  one-cycle pulse when a full run with blink completes
- run_count  out  CNT_W  completed runs, saturating at all-ones

Behaviour:
- Reset (rst=1 at posedge): led_q=0, level=0, dir=IDLE, err=0, err_code=0, run_done=0, run_count=0, blink_n=0, saw16=0. All outputs are registered.
- Each cycle, compare led against led_q (last sample); led_q<=led always.
  - up step: led=={led_q[14:0],1'b1} and led_q!=16'hFFFF
  - down step: led==led_q>>1 and led_q!=0
  - hold: led==led_q
  - toggle: led==~led_q and led_q is 0000 or FFFF
- FSM states: IDLE, RISE, FALL, BLINK.
  - IDLE: hold at 0 stays. Up step -> RISE, level=1. Any other change -> err_code=1, state stays IDLE, level=0.
  - RISE: up step -> level+1. Down step -> turn-down at peak level_q.
    - Peak must be PEAK_A, PEAK_B or 16; otherwise err_code=2.
    - Peak 16 sets saw16.
    - State -> FALL, level-1.
  - FALL: down step -> level-1. Up step -> turn-up at trough level_q.
    - Trough must be 0 or TROUGH_B; otherwise err_code=3.
    - State -> RISE.
  - FALL reaching level 0:
    - If saw16=1, next state is BLINK with blink_n=0.
    - Otherwise stay in FALL, waiting for an up step.
  - BLINK: each toggle increments blink_n and sets level to 16 or 0 per led.
    - When blink_n reaches 2 with led=0: run_done=1 for one cycle, run_count+1 (saturating), saw16=0, state -> IDLE.
    - Holds are allowed in BLINK.
  - Any change not in the legal set for the current state: err_code=1 (step). Then resync: level=popcount-free reload (0 if led==0, 16 if FFFF, else keep level_q), state -> IDLE if led==0, else stays.
- Sticky error: err/err_code latch the first error only; later errors are ignored until clr_err or rst. clr_err in the same cycle as a new error: the new error wins.
- Hold in any state keeps level/dir unchanged; holds of any length are legal.
- led==0 seen during RISE: treated as a step error unless it is a legal down step from level 1.
- Reset mid-run: everything returns to reset values next cycle. The first sample after reset is compared against led_q=0.
- Latency: level/dir/err reflect the led value sampled one clock earlier.

Decomposition:
- Shared package holds:
  - dir encodings DIR_IDLE/RISE/FALL/BLINK
  - err codes ERR_NONE/STEP/PEAK/TROUGH
  - LED_W=16
- One sub-module: led_step_classifier. Purely combinational; takes led, led_q and returns up/down/hold/toggle flags. It is instantiated once.

Test Plan:
- Nominal run, no flick: 0 -> levels 1..6, down to 0, up to 11, down to 5, up to 16, down to 0, toggle FFFF, 0000 -> run_done pulses once, run_count=1, err=0, dir back to 0.
- Kickback: rise to 11, fall to 5, rise to 11 again, fall to 5, then finish run -> no error, run_count=1.
- Illegal peak: rise to 8 then down to 7 -> err=1, err_code=2 on the cycle after 7 is sampled.
- Illegal step: led jumps 0x003F -> 0x00FF -> err_code=1. Then 0x00F0 -> err_code stays 1 (first error kept). clr_err -> err=0.
- Bad trough: fall from 11 to 3, then up to 4 -> err_code=3.
- Reset mid-run at level 9 with rst=1 for one cycle -> level=0, dir=0, run_count unchanged only if previously 0 (reset clears it to 0); next run counts from 1.
